// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU pipeline.
//   - Opcode constants used by fetch and execute.
//   - IMM_MARKER: value of the z field that marks a two-word MOV.
//   - fetch_state_t: state encoding of the instruction fetch FSM.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] OP_MOV  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_IN   = 4'h7;
   localparam logic [3:0] OP_OUT  = 4'h8;
   localparam logic [3:0] OP_STOP = 4'hF;

   // A MOV whose z field holds this value carries a second (immediate) word.
   localparam logic [3:0] IMM_MARKER = 4'h8;

   typedef enum logic [2:0] {
      ISSUE,
      CAP1,
      CAP2,
      VALID,
      HALT
   } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the 16-bit CPU. Addresses a synchronous-read program memory
// (one cycle read latency), captures the instruction word and an optional
// immediate word, splits the instruction into fields and offers it to the
// execute stage over a valid/ready handshake. Supports PC redirect from
// execute and freezes after a STOP instruction is accepted.
//
// Optional build macro:
//   INSTR_FETCH_CNT_EN - adds output instr_count[15:0], a saturating count of
//                        accepted instructions.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   mem_addr     program memory address (registered)
//   mem_we       program memory write enable, always 0
//   mem_rdata    program memory read data, valid one cycle after mem_addr
//   pc_load      redirect request from execute
//   pc_new       redirect target address
//   ir_valid     decoded instruction available
//   ir_ready     execute accepts the instruction
//   ir_opcode    instr[15:12]
//   ir_x         instr[11:8]
//   ir_y         instr[7:4]
//   ir_z         instr[3:0]
//   ir_imm       second word of a two-word instruction, else 0
//   ir_has_imm   instruction was two words
//   ir_pc        address of the first word of the current instruction
//   halted       STOP accepted, fetch frozen until reset
//   instr_count  accepted-instruction counter (INSTR_FETCH_CNT_EN only)
// -----------------------------------------------------------------------------
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int RESET_PC   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_new,
`ifdef INSTR_FETCH_CNT_EN
   output logic [15:0]           instr_count,
`endif
   output logic                  ir_valid,
   input  logic                  ir_ready,
   output logic [3:0]            ir_opcode,
   output logic [3:0]            ir_x,
   output logic [3:0]            ir_y,
   output logic [3:0]            ir_z,
   output logic [DATA_WIDTH-1:0] ir_imm,
   output logic                  ir_has_imm,
   output logic [ADDR_WIDTH-1:0] ir_pc,
   output logic                  halted
);

   localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

   fetch_state_t          state;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic                  accept;
   logic                  two_word;
   logic                  redirect;

   assign mem_we   = 1'b0;
   assign pc_inc   = pc + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
   assign accept   = ir_valid & ir_ready;
   assign two_word = (mem_rdata[15:12] == OP_MOV) && (mem_rdata[3:0] == IMM_MARKER);

   // Redirect is honoured everywhere except HALT, and loses only to an
   // accepted STOP in the same cycle.
   assign redirect = pc_load && (state != HALT) && !(accept && (ir_opcode == OP_STOP));

   // NOTE: all state below is sequential, so every assignment is non-blocking;
   // a blocking assignment here would let later statements see the new value
   // within the same clock edge and create ordering-dependent behaviour.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ISSUE;
         pc         <= PC_RST;
         mem_addr   <= PC_RST;
         ir_valid   <= 1'b0;
         halted     <= 1'b0;
         ir_opcode  <= '0;
         ir_x       <= '0;
         ir_y       <= '0;
         ir_z       <= '0;
         ir_imm     <= '0;
         ir_has_imm <= 1'b0;
         ir_pc      <= PC_RST;
      end else if (redirect) begin
         // Abort whatever was in flight and restart fetch at the new target.
         state    <= ISSUE;
         pc       <= pc_new;
         mem_addr <= pc_new;
         ir_valid <= 1'b0;
      end else begin
         case (state)
            ISSUE: begin
               // The first word is addressed now; present the following
               // address during CAP1 so a possible immediate word is already
               // on mem_rdata when CAP2 runs.
               mem_addr <= pc_inc;
               state    <= CAP1;
            end

            CAP1: begin
               ir_opcode  <= mem_rdata[15:12];
               ir_x       <= mem_rdata[11:8];
               ir_y       <= mem_rdata[7:4];
               ir_z       <= mem_rdata[3:0];
               ir_imm     <= '0;
               ir_has_imm <= 1'b0;
               ir_pc      <= pc;
               pc         <= pc_inc;
               if (two_word) begin
                  state <= CAP2;
               end else begin
                  state    <= VALID;
                  ir_valid <= 1'b1;
               end
            end

            CAP2: begin
               ir_imm     <= mem_rdata;
               ir_has_imm <= 1'b1;
               pc         <= pc_inc;
               mem_addr   <= pc_inc;
               state      <= VALID;
               ir_valid   <= 1'b1;
            end

            VALID: begin
               if (accept) begin
                  ir_valid <= 1'b0;
                  if (ir_opcode == OP_STOP) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end

            HALT: begin
               // Frozen until reset.
            end

            default: begin
               state <= ISSUE;
            end
         endcase
      end
   end

`ifdef INSTR_FETCH_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_count <= '0;
      end else if (accept && (instr_count != 16'hFFFF)) begin
         instr_count <= instr_count + 16'd1;
      end
   end
`endif

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. Two instances share one program memory
// model: dut starts at address 8, wdut starts at address 63 to exercise
// address wrap between the two words of an instruction.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
   import cpu_pkg::*;

   localparam int AW = 6;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          pc_load;
   logic [AW-1:0] pc_new;
   logic          ir_ready;

   logic [DW-1:0] mem [64];

   // Instance starting at 8
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          ir_valid;
   logic [3:0]    ir_opcode, ir_x, ir_y, ir_z;
   logic [DW-1:0] ir_imm;
   logic          ir_has_imm;
   logic [AW-1:0] ir_pc;
   logic          halted;

   // Instance starting at 63
   logic [AW-1:0] w_addr;
   logic          w_we;
   logic [DW-1:0] w_rdata;
   logic          w_valid;
   logic [3:0]    w_opcode, w_x, w_y, w_z;
   logic [DW-1:0] w_imm;
   logic          w_has_imm;
   logic [AW-1:0] w_pc;
   logic          w_halted;

`ifdef INSTR_FETCH_CNT_EN
   logic [15:0]   instr_count;
   logic [15:0]   w_count;
`endif

   instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .pc_load(pc_load), .pc_new(pc_new),
`ifdef INSTR_FETCH_CNT_EN
      .instr_count(instr_count),
`endif
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .ir_opcode(ir_opcode), .ir_x(ir_x), .ir_y(ir_y), .ir_z(ir_z),
      .ir_imm(ir_imm), .ir_has_imm(ir_has_imm), .ir_pc(ir_pc), .halted(halted)
   );

   instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(63)) wdut (
      .clk(clk), .rst_n(rst_n),
      .mem_addr(w_addr), .mem_we(w_we), .mem_rdata(w_rdata),
      .pc_load(pc_load), .pc_new(pc_new),
`ifdef INSTR_FETCH_CNT_EN
      .instr_count(w_count),
`endif
      .ir_valid(w_valid), .ir_ready(ir_ready),
      .ir_opcode(w_opcode), .ir_x(w_x), .ir_y(w_y), .ir_z(w_z),
      .ir_imm(w_imm), .ir_has_imm(w_has_imm), .ir_pc(w_pc), .halted(w_halted)
   );

   // Synchronous-read program memory, one read port per instance.
   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      w_rdata   <= mem[w_addr];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench one step after the first non-reset edge is armed:
   // the current cycle is the first ISSUE cycle.
   task automatic do_reset();
      rst_n    = 1'b0;
      pc_load  = 1'b0;
      ir_ready = 1'b0;
      pc_new   = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // n is the cycle index (ISSUE cycle = 1) at which ir_valid is seen.
   task automatic wait_valid(input bit sel, output int n);
      n = 1;
      while (((sel ? w_valid : ir_valid) !== 1'b1) && n < 20) begin
         tick();
         n++;
      end
      check("valid_within_bound", 32'(sel ? w_valid : ir_valid), 32'(1));
   endtask

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      logic [3:0]  op, x, y, z;
      logic        has;
      logic [15:0] imm;
      int          lat;
      logic [5:0]  nxt;
   } vec_t;

   vec_t vt [6];

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      if ($urandom_range(0, 3) == 0) begin
         w[15:12] = 4'h0;
         w[3:0]   = 4'h8;
      end
      return w;
   endfunction

   initial begin
      int n;
      rst_n    = 1'b0;
      pc_load  = 1'b0;
      pc_new   = '0;
      ir_ready = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 16'h7000;

      vt[0] = '{16'h7101, 16'h0000, 4'h7, 4'h1, 4'h0, 4'h1, 1'b0, 16'h0000, 3, 6'd9};
      vt[1] = '{16'h0108, 16'h1234, 4'h0, 4'h1, 4'h0, 4'h8, 1'b1, 16'h1234, 4, 6'd10};
      vt[2] = '{16'h0107, 16'hBEEF, 4'h0, 4'h1, 4'h0, 4'h7, 1'b0, 16'h0000, 3, 6'd9};
      vt[3] = '{16'h1808, 16'h5555, 4'h1, 4'h8, 4'h0, 4'h8, 1'b0, 16'h0000, 3, 6'd9};
      vt[4] = '{16'h3ABC, 16'h0001, 4'h3, 4'hA, 4'hB, 4'hC, 1'b0, 16'h0000, 3, 6'd9};
      vt[5] = '{16'h0FF8, 16'hFFFF, 4'h0, 4'hF, 4'hF, 4'h8, 1'b1, 16'hFFFF, 4, 6'd10};

      // ---- Table-driven single instructions after reset ----
      for (int i = 0; i < 6; i++) begin
         mem[8] = vt[i].w0;
         mem[9] = vt[i].w1;
         do_reset();
         check("rst_mem_addr", 32'(mem_addr), 32'(8));
         check("rst_ir_valid", 32'(ir_valid), 32'(0));
         check("rst_halted", 32'(halted), 32'(0));
         check("rst_mem_we", 32'(mem_we), 32'(0));
         check("rst_fields", 32'({ir_opcode, ir_x, ir_y, ir_z}), 32'(0));
         check("rst_imm", 32'({ir_has_imm, ir_imm}), 32'(0));
         check("rst_ir_pc", 32'(ir_pc), 32'(8));
         wait_valid(1'b0, n);
         check("vec_latency", 32'(n), 32'(vt[i].lat));
         check("vec_opcode", 32'(ir_opcode), 32'(vt[i].op));
         check("vec_x", 32'(ir_x), 32'(vt[i].x));
         check("vec_y", 32'(ir_y), 32'(vt[i].y));
         check("vec_z", 32'(ir_z), 32'(vt[i].z));
         check("vec_has_imm", 32'(ir_has_imm), 32'(vt[i].has));
         check("vec_imm", 32'(ir_imm), 32'(vt[i].imm));
         check("vec_ir_pc", 32'(ir_pc), 32'(8));
         ir_ready = 1'b1;
         tick();
         ir_ready = 1'b0;
         check("vec_accepted", 32'(ir_valid), 32'(0));
         check("vec_next_addr", 32'(mem_addr), 32'(vt[i].nxt));
      end

      // ---- Backpressure: five cycles of ir_ready=0 in VALID ----
      mem[8] = 16'h7101;
      do_reset();
      wait_valid(1'b0, n);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(ir_valid), 32'(1));
         check("bp_fields", 32'({ir_opcode, ir_x, ir_y, ir_z}), 32'(16'h7101));
         check("bp_ir_pc", 32'(ir_pc), 32'(8));
         check("bp_mem_addr", 32'(mem_addr), 32'(9));
         tick();
      end
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      check("bp_accepted", 32'(ir_valid), 32'(0));
      check("bp_next_addr", 32'(mem_addr), 32'(9));

      // ---- Redirect during CAP1 ----
      mem[20] = 16'h2345;
      do_reset();
      tick();                       // now in the capture cycle
      pc_load = 1'b1;
      pc_new  = 6'd20;
      tick();
      pc_load = 1'b0;
      check("redir_valid_low", 32'(ir_valid), 32'(0));
      check("redir_mem_addr", 32'(mem_addr), 32'(20));
      wait_valid(1'b0, n);
      check("redir_latency", 32'(n), 32'(3));
      check("redir_ir_pc", 32'(ir_pc), 32'(20));
      check("redir_fields", 32'({ir_opcode, ir_x, ir_y, ir_z}), 32'(16'h2345));

      // ---- Redirect in the same cycle as a handshake: redirect wins ----
      mem[30] = 16'h8123;
      ir_ready = 1'b1;
      pc_load  = 1'b1;
      pc_new   = 6'd30;
      tick();
      ir_ready = 1'b0;
      pc_load  = 1'b0;
      check("hs_redir_valid_low", 32'(ir_valid), 32'(0));
      check("hs_redir_mem_addr", 32'(mem_addr), 32'(30));
      wait_valid(1'b0, n);
      check("hs_redir_ir_pc", 32'(ir_pc), 32'(30));
      check("hs_redir_opcode", 32'(ir_opcode), 32'(OP_OUT));

      // ---- STOP with a simultaneous redirect: HALT wins, then frozen ----
      mem[8] = 16'hF000;
      do_reset();
      wait_valid(1'b0, n);
      check("stop_opcode", 32'(ir_opcode), 32'(OP_STOP));
      ir_ready = 1'b1;
      pc_load  = 1'b1;
      pc_new   = 6'd5;
      tick();
      for (int k = 0; k < 4; k++) begin
         check("halt_halted", 32'(halted), 32'(1));
         check("halt_valid_low", 32'(ir_valid), 32'(0));
         check("halt_mem_addr", 32'(mem_addr), 32'(9));
         tick();
      end
      do_reset();
      check("halt_reset_halted", 32'(halted), 32'(0));
      check("halt_reset_mem_addr", 32'(mem_addr), 32'(8));

      // ---- Wrap: two-word instruction at 63, immediate at 0 ----
      mem[63] = 16'h0108;
      mem[0]  = 16'hCAFE;
      mem[1]  = 16'h7101;
      do_reset();
      check("wrap_rst_addr", 32'(w_addr), 32'(63));
      wait_valid(1'b1, n);
      check("wrap_latency", 32'(n), 32'(4));
      check("wrap_has_imm", 32'(w_has_imm), 32'(1));
      check("wrap_imm", 32'(w_imm), 32'(16'hCAFE));
      check("wrap_ir_pc", 32'(w_pc), 32'(63));
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      check("wrap_valid_low", 32'(w_valid), 32'(0));
      check("wrap_next_addr", 32'(w_addr), 32'(1));

      // ---- Randomised run against a transaction-level model ----
      // Model: an instruction whose fetch starts in cycle s is presented from
      // cycle s+2 (one word) or s+3 (two words) until accepted; the next fetch
      // starts the cycle after acceptance at the following address, or the
      // cycle after a redirect at the redirect target.
      for (int i = 0; i < 64; i++) mem[i] = rand_word();
      do_reset();
      begin
         int          cyc;
         int          s;
         logic [5:0]  exp_pc;
         logic [5:0]  nx;
         logic [15:0] w0;
         bit          two;
         bit          ev;
         cyc    = 0;
         s      = 0;
         exp_pc = 6'd8;
         for (int t = 0; t < 1500; t++) begin
            w0  = mem[exp_pc];
            nx  = exp_pc + 6'd1;
            two = (w0[15:12] == OP_MOV) && (w0[3:0] == IMM_MARKER);
            ev  = (cyc >= s + (two ? 3 : 2));
            check("rnd_valid", 32'(ir_valid), 32'(ev));
            if (cyc == s) check("rnd_mem_addr", 32'(mem_addr), 32'(exp_pc));
            if (ev) begin
               check("rnd_fields", 32'({ir_opcode, ir_x, ir_y, ir_z}), 32'(w0));
               check("rnd_ir_pc", 32'(ir_pc), 32'(exp_pc));
               check("rnd_has_imm", 32'(ir_has_imm), 32'(two));
               check("rnd_imm", 32'(ir_imm), 32'(two ? mem[nx] : 16'h0000));
            end
            ir_ready = ($urandom_range(0, 2) != 0);
            pc_load  = ($urandom_range(0, 19) == 0);
            pc_new   = 6'($urandom);
            if (pc_load) begin
               exp_pc = pc_new;
               s      = cyc + 1;
            end else if (ev && ir_ready) begin
               exp_pc = exp_pc + (two ? 6'd2 : 6'd1);
               s      = cyc + 1;
            end
            tick();
            cyc++;
         end
      end
      pc_load  = 1'b0;
      ir_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_instr_fetch
